copro_result_fifo: RTL and testbench
====================================

# copro_result_fifo

Result buffer stage sitting directly downstream of the coprocessor ALU in the CV-X-IF example coprocessor. It captures each one-cycle ALU result pulse (result, hartid, id, rd, we), queues it in a small circular FIFO, and presents it to the core's result interface with a valid/ready handshake. It also issues credits back to the issue stage, so the ALU, which has no backpressure, can never produce a result the buffer cannot hold.

## Interface
- XLEN, 32, result data width
- Depth, 4, FIFO entries; power of two, >= 2
- hartid_t, logic, hart identifier type
- id_t, logic, instruction identifier type

- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- issue_valid_i  input  1  issue stage launches one instruction into the ALU this cycle
- issue_ready_o  output  1  a buffer slot is reserved-free; issue allowed
- alu_valid_i  input  1  ALU result valid (one-cycle pulse)
- alu_result_i  input  XLEN  ALU result
- alu_hartid_i  input  hartid_t  hart of result
- alu_id_i  input  id_t  instruction id
- alu_rd_i  input  5  destination register
- alu_we_i  input  1  register write enable
- result_valid_o  output  1  head entry valid toward core
- result_ready_i  input  1  core accepts head entry
- result_data_o  output  XLEN  head result
- result_hartid_o  output  hartid_t  head hartid
- result_id_o  output  id_t  head id
- result_rd_o  output  5  head rd
- result_we_o  output  1  head we
- count_o  output  $clog2(Depth+1)  current occupancy
- overflow_o  output  1  sticky error: push attempted while full without simultaneous pop

## Operation
- Storage: Depth entries of {result, hartid, id, rd, we}; write pointer, read pointer ($clog2(Depth) bits, wrap modulo Depth), occupancy count (0..Depth).
- Push: alu_valid_i=1 writes entry at write pointer, pointer increments. Payload fields captured only on push; entries not cleared on pop.
- Pop: result_valid_o && result_ready_i; read pointer increments.
- result_valid_o = (count != 0). Outputs driven from entry at read pointer; stable while result_valid_o=1 and result_ready_i=0.
- No bypass: a pushed entry is visible at the outputs no earlier than the cycle after the push.
- Simultaneous push+pop: count unchanged, both pointers advance; legal at any occupancy including full and empty+1.
- Full (count=Depth) push without pop: entry dropped, pointers and count unchanged, overflow_o set and held until reset.
- Push on empty with pop: impossible (result_valid_o=0), no pop occurs.
- Credits: reserved counter (0..Depth) = instructions issued and not yet popped. +1 on issue_valid_i && issue_ready_o; -1 on pop; both same cycle: unchanged.
- issue_ready_o = (reserved < Depth), derived from registered state only; no combinational path from result_ready_i or alu_valid_i.
- issue_valid_i while issue_ready_o=0 is ignored by the credit counter.
- Correct upstream use never triggers overflow_o.

## Timing
- Reset (rst_i high, async): count=0, reserved=0, pointers=0, overflow_o=0, result_valid_o=0, result_* payload outputs 0 (storage reset to 0), count_o=0, issue_ready_o=1.
- Reset mid-operation: all queued entries and credits discarded immediately; outputs take reset values in the same cycle rst_i rises, independent of clock.
- Latency: alu_valid_i at cycle N -> result_valid_o at N+1 if FIFO was empty.
- ALU latency is 1 cycle: issue at N -> alu_valid_i at N+1 -> earliest result_valid_o at N+2.
- Throughput: one push and one pop per cycle sustained.
- issue_ready_o updates the cycle after a pop frees a credit (credit return latency 1).
- overflow_o rises the cycle after the offending push.

## Test plan
- Reset then single issue/result, Depth=4: issue at cycle 1, alu_valid_i at 2 with result 0x00000042, rd=5, id=3 -> result_valid_o=1 at 3 with same fields; ready=1 at 3 -> count_o=0, issue_ready_o=1 at 4.
- Fill: 4 issues back-to-back with result_ready_i=0 -> issue_ready_o=0 after 4th issue; count_o reaches 4; 5th issue_valid_i ignored; outputs hold entry 0.
- Stream with wrap-around: 12 consecutive issues, result_ready_i=1 always -> results emerge in order (ids 0..11), one per cycle, count_o never exceeds 1, no overflow.
- Full with simultaneous push+pop: count=4, drive alu_valid_i and result_ready_i same cycle -> count stays 4, head advances, overflow_o=0; then push with ready=0 -> overflow_o=1 sticky.
- Random backpressure: 1000 issues, result_ready_i random 50% -> in-order delivery, no loss, overflow_o=0, reserved never exceeds 4.
- Async reset with 3 queued entries mid-cycle -> result_valid_o=0, count_o=0, issue_ready_o=1 immediately, before next clock edge.

Source files
------------

// File: rtl/copro_result_fifo.sv
// copro_result_fifo
// Result buffer between the coprocessor ALU and the core result interface.
// Each one-cycle ALU result pulse is queued in a circular FIFO and offered to
// the core with a valid/ready handshake. A credit counter toward the issue
// stage keeps the number of in-flight plus buffered results within DEPTH, so
// the ALU (which cannot be stalled) never pushes into a full buffer.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   issue_valid_i        issue stage launches an instruction this cycle
//   issue_ready_o        a buffer slot is still unreserved; issue allowed
//   alu_valid_i          ALU result pulse, with result/hartid/id/rd/we payload
//   result_valid_o       head entry valid toward the core
//   result_ready_i       core accepts the head entry
//   result_*_o           head entry payload
//   count_o              current FIFO occupancy
//   overflow_o           sticky: push while full without a simultaneous pop
module copro_result_fifo #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned DEPTH    = 4,
   parameter type         hartid_t = logic,
   parameter type         id_t     = logic
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           issue_valid_i,
   output logic                           issue_ready_o,
   input  logic                           alu_valid_i,
   input  logic [XLEN-1:0]                alu_result_i,
   input  hartid_t                        alu_hartid_i,
   input  id_t                            alu_id_i,
   input  logic [4:0]                     alu_rd_i,
   input  logic                           alu_we_i,
   output logic                           result_valid_o,
   input  logic                           result_ready_i,
   output logic [XLEN-1:0]                result_data_o,
   output hartid_t                        result_hartid_o,
   output id_t                            result_id_o,
   output logic [4:0]                     result_rd_o,
   output logic                           result_we_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output logic                           overflow_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] result;
      hartid_t         hartid;
      id_t             id;
      logic [4:0]      rd;
      logic            we;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   reserved;
   logic               overflow;

   logic full;
   logic pop;
   logic push_ok;
   logic issue_fire;

   assign full       = (count == CNT_W'(DEPTH));
   assign pop        = result_valid_o && result_ready_i;
   // A push into a full buffer only lands if the head leaves in the same cycle.
   assign push_ok    = alu_valid_i && (!full || pop);
   assign issue_fire = issue_valid_i && issue_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         reserved <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= '{result: alu_result_i, hartid: alu_hartid_i,
                             id: alu_id_i, rd: alu_rd_i, we: alu_we_i};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_ok && !pop) begin
            count <= count + CNT_W'(1);
         end else if (!push_ok && pop) begin
            count <= count - CNT_W'(1);
         end
         if (alu_valid_i && full && !pop) begin
            overflow <= 1'b1;
         end
         // Credits return on pop, not on push: a slot stays reserved until
         // the core has taken the result out of the buffer.
         if (issue_fire && !pop) begin
            reserved <= reserved + CNT_W'(1);
         end else if (!issue_fire && pop) begin
            reserved <= reserved - CNT_W'(1);
         end
      end
   end

   // issue_ready_o depends on registered state only, so there is no
   // combinational path from result_ready_i or alu_valid_i.
   assign issue_ready_o   = (reserved < CNT_W'(DEPTH));
   assign result_valid_o  = (count != '0);
   assign result_data_o   = mem[rd_ptr].result;
   assign result_hartid_o = mem[rd_ptr].hartid;
   assign result_id_o     = mem[rd_ptr].id;
   assign result_rd_o     = mem[rd_ptr].rd;
   assign result_we_o     = mem[rd_ptr].we;
   assign count_o         = count;
   assign overflow_o      = overflow;

endmodule

// File: tb/tb_copro_result_fifo.sv
// Directed testbench for copro_result_fifo (DEPTH=4, 2-bit hartid, 4-bit id).
module tb_copro_result_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic        alu_valid;
   logic [31:0] alu_result;
   logic [1:0]  alu_hartid;
   logic [3:0]  alu_id;
   logic [4:0]  alu_rd;
   logic        alu_we;
   logic        result_valid;
   logic        result_ready;
   logic [31:0] result_data;
   logic [1:0]  result_hartid;
   logic [3:0]  result_id;
   logic [4:0]  result_rd;
   logic        result_we;
   logic [2:0]  count;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   copro_result_fifo #(
      .XLEN(32), .DEPTH(4), .hartid_t(logic [1:0]), .id_t(logic [3:0])
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
      .alu_valid_i(alu_valid), .alu_result_i(alu_result),
      .alu_hartid_i(alu_hartid), .alu_id_i(alu_id),
      .alu_rd_i(alu_rd), .alu_we_i(alu_we),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_data_o(result_data), .result_hartid_o(result_hartid),
      .result_id_o(result_id), .result_rd_o(result_rd),
      .result_we_o(result_we), .count_o(count), .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic av, input logic [31:0] d,
                        input logic [3:0] id, input logic [4:0] rd, input logic rdy);
      issue_valid  = iv;
      alu_valid    = av;
      alu_result   = d;
      alu_id       = id;
      alu_rd       = rd;
      alu_we       = av;
      alu_hartid   = 2'd1;
      result_ready = rdy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          exp_id;
      int          issued;
      int          popped;
      int          alu_tag;
      int          cyc;
      logic        pend;
      logic        fire;
      logic        rdy;
      logic [31:0] exp_data;

      // Reset state
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_valid", result_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_overflow", overflow, 0);
      chk("rst_data", result_data, 0);
      tick; tick;
      rst = 1'b0;

      // Single issue / result
      drive(1, 0, 0, 0, 0, 0);
      tick;
      drive(0, 1, 32'h42, 4'd3, 5'd5, 0);
      chk("no_bypass_valid", result_valid, 0);
      tick;
      drive(0, 0, 0, 0, 0, 1);
      chk("single_valid", result_valid, 1);
      chk("single_data", result_data, 32'h42);
      chk("single_id", result_id, 3);
      chk("single_rd", result_rd, 5);
      chk("single_we", result_we, 1);
      chk("single_hartid", result_hartid, 1);
      chk("single_count", count, 1);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("single_count_after", count, 0);
      chk("single_issue_ready_after", issue_ready, 1);
      chk("single_valid_after", result_valid, 0);

      // Fill: four issues, no pops
      drive(1, 0, 0, 0, 0, 0);
      tick;
      drive(1, 1, 32'hA0, 4'd0, 5'd1, 0);
      tick;
      drive(1, 1, 32'hA1, 4'd1, 5'd2, 0);
      tick;
      drive(1, 1, 32'hA2, 4'd2, 5'd3, 0);
      tick;
      chk("fill_issue_ready_low", issue_ready, 0);
      drive(1, 1, 32'hA3, 4'd3, 5'd4, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("fill_count", count, 4);
      chk("fill_issue_ready_held", issue_ready, 0);
      chk("fill_head_data", result_data, 32'hA0);
      chk("fill_head_id", result_id, 0);
      tick;
      chk("fill_head_stable", result_data, 32'hA0);

      // Full with simultaneous push and pop
      drive(0, 1, 32'hA4, 4'd4, 5'd5, 1);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("full_pp_count", count, 4);
      chk("full_pp_head", result_data, 32'hA1);
      chk("full_pp_overflow", overflow, 0);
      chk("full_pp_issue_ready", issue_ready, 1);
      // Push while full without pop is dropped and flags overflow
      drive(0, 1, 32'hA5, 4'd5, 5'd6, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 4);
      chk("ovf_head", result_data, 32'hA1);
      tick;
      chk("ovf_sticky", overflow, 1);
      drive(0, 0, 0, 0, 0, 1);
      tick;
      chk("drain_head1", result_data, 32'hA2);
      tick;
      chk("drain_head2", result_data, 32'hA3);
      tick;
      chk("drain_head3_wrap", result_data, 32'hA4);
      chk("drain_count", count, 1);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("ovf_cleared_by_reset", overflow, 0);
      tick;
      rst = 1'b0;

      // Streaming with wrap-around
      exp_id = 0;
      for (int c = 0; c < 16; c++) begin
         drive(c < 12, (c >= 1) && (c <= 12), 32'(c + 99), 4'(c - 1), 5'd7, 1);
         if (result_valid) begin
            chk("stream_id", result_id, exp_id);
            exp_id++;
         end
         chk("stream_count_le1", count <= 1, 1);
         tick;
      end
      chk("stream_total", exp_id, 12);
      chk("stream_overflow", overflow, 0);

      // Random backpressure, credit-respecting upstream
      issued   = 0;
      popped   = 0;
      alu_tag  = 0;
      pend     = 1'b0;
      cyc      = 0;
      exp_data = 32'h1000;
      while (popped < 1000 && cyc < 20000) begin
         fire = (issued < 1000) && issue_ready;
         rdy  = 1'($urandom_range(0, 1));
         drive(issued < 1000, pend, 32'h1000 + 32'(alu_tag), 4'(alu_tag), 5'd9, rdy);
         if (pend) alu_tag++;
         if (fire) issued++;
         if (result_valid && rdy) begin
            chk("rand_order", result_data, exp_data);
            exp_data++;
            popped++;
         end
         if (count > 4) chk("rand_count_bound", count, 4);
         tick;
         pend = fire;
         cyc++;
      end
      chk("rand_popped", popped, 1000);
      chk("rand_overflow", overflow, 0);
      drive(0, pend, 32'h1000 + 32'(alu_tag), 4'(alu_tag), 5'd9, 1);
      tick;
      drive(0, 0, 0, 0, 0, 1);
      tick; tick; tick; tick; tick;
      chk("rand_drained", count, 0);

      // Async reset mid-cycle with three queued entries
      drive(1, 0, 0, 0, 0, 0);
      tick;
      drive(1, 1, 32'hB0, 4'd0, 5'd1, 0);
      tick;
      drive(1, 1, 32'hB1, 4'd1, 5'd1, 0);
      tick;
      drive(0, 1, 32'hB2, 4'd2, 5'd1, 0);
      tick;
      drive(0, 0, 0, 0, 0, 0);
      chk("arst_pre_count", count, 3);
      chk("arst_pre_issue_ready", issue_ready, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", result_valid, 0);
      chk("arst_count", count, 0);
      chk("arst_issue_ready", issue_ready, 1);
      chk("arst_data", result_data, 0);
      #1;
      rst = 1'b0;
      tick;
      chk("arst_after_valid", result_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
